// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle controller
package mc_pkg;

    // FSM state encodings (4-bit, exported on the debug state port)
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_ALU   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Supported R-type function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALUOp
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    // ALUSrcB
    localparam logic [1:0] SRCB_BUSB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PCSrc
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ExtOp
    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_MEM,
        CLS_BR,
        CLS_J,
        CLS_ILL
    } instr_cls_e;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct classifier
// Ports: i_opcode/i_funct instruction fields; o_cls instruction class;
//        o_illegal set for unknown opcodes and unsupported R-type functs.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    output instr_cls_e  o_cls,
    output logic        o_illegal
);

    always_comb begin
        o_cls = CLS_ILL;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_SLL, FN_ADDU, FN_SUBU,
                    FN_AND, FN_OR, FN_SLT: o_cls = CLS_R;
                    default:               o_cls = CLS_ILL;
                endcase
            end
            OP_ADDIU, OP_ORI, OP_LUI: o_cls = CLS_I;
            OP_LW, OP_SW:             o_cls = CLS_MEM;
            OP_BEQ:                   o_cls = CLS_BR;
            OP_J, OP_JAL:             o_cls = CLS_J;
            default:                  o_cls = CLS_ILL;
        endcase
        o_illegal = (o_cls == CLS_ILL);
    end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset control FSM
// Ports: clk/rst (sync, active-high); opcode/funct/zero/mem_ack inputs;
//        memory, PC, ALU and register-file control outputs; state (debug);
//        instr_done/illegal pulses; retired_cnt retired-instruction count.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        IorD,
    output logic        IRWr,
    output logic        PCWr,
    output logic        PCWrCond,
    output logic [1:0]  PCSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        RegWr,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        Link,
    output logic [1:0]  ExtOp,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] retired_cnt
);

    logic [3:0]  r_state;
    logic [31:0] r_retired_cnt;
    logic [31:0] r_hold;

    logic [3:0]  w_next;
    instr_cls_e  w_cls;
    logic        w_dec_illegal;
    logic        w_mem_req, w_mem_we, w_iord, w_irwr, w_pcwr, w_pcwrcond;
    logic [1:0]  w_pcsrc, w_alusrcb, w_aluop, w_extop;
    logic        w_alusrca, w_regwr, w_regdst, w_memtoreg, w_link;
    logic        w_done, w_illegal;
    // The zero flag is consumed by the datapath through PCWrCond.
    logic        w_unused_zero;

    assign w_unused_zero = zero;

    mc_decode u_decode (
        .i_opcode  (opcode),
        .i_funct   (funct),
        .o_cls     (w_cls),
        .o_illegal (w_dec_illegal)
    );

    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_iord     = 1'b0;
        w_irwr     = 1'b0;
        w_pcwr     = 1'b0;
        w_pcwrcond = 1'b0;
        w_pcsrc    = PCSRC_ALU;
        w_alusrca  = 1'b0;
        w_alusrcb  = SRCB_BUSB;
        w_aluop    = ALU_ADD;
        w_regwr    = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_link     = 1'b0;
        w_extop    = EXT_ZERO;
        w_done     = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                // No request while the post-reset hold is still counting down.
                w_mem_req = (r_hold == 32'd0);
                w_alusrcb = SRCB_FOUR;
                if (w_mem_req && mem_ack) begin
                    w_irwr = 1'b1;
                    w_pcwr = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut here.
                w_alusrcb = SRCB_IMM_SH2;
                case (w_cls)
                    CLS_R:   w_next = S_EXEC_R;
                    CLS_I:   w_next = S_EXEC_I;
                    CLS_MEM: w_next = S_MEM_ADDR;
                    CLS_BR:  w_next = S_BRANCH;
                    CLS_J:   w_next = S_JUMP;
                    default: begin
                        w_illegal = w_dec_illegal;
                        w_done    = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                w_alusrca = 1'b1;
                w_aluop   = ALU_FUNCT;
                w_next    = S_WB_ALU;
            end
            S_EXEC_I: begin
                w_alusrca = 1'b1;
                w_alusrcb = SRCB_IMM;
                case (opcode)
                    OP_ADDIU: begin w_aluop = ALU_ADD;   w_extop = EXT_SIGN;  end
                    OP_ORI:   begin w_aluop = ALU_LOGIC; w_extop = EXT_ZERO;  end
                    default:  begin w_aluop = ALU_LOGIC; w_extop = EXT_UPPER; end
                endcase
                w_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_regwr  = 1'b1;
                w_regdst = (opcode == OP_RTYPE);
                w_done   = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_alusrca = 1'b1;
                w_alusrcb = SRCB_IMM;
                w_extop   = EXT_SIGN;
                w_next    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (mem_ack) w_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_iord    = 1'b1;
                if (mem_ack) begin
                    w_done = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_WB_MEM: begin
                w_regwr    = 1'b1;
                w_memtoreg = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                w_alusrca  = 1'b1;
                w_aluop    = ALU_SUB;
                w_pcwrcond = 1'b1;
                w_pcsrc    = PCSRC_ALUOUT;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                w_pcwr  = 1'b1;
                w_pcsrc = PCSRC_JUMP;
                w_link  = (opcode == OP_JAL);
                w_regwr = (opcode == OP_JAL);
                w_done  = 1'b1;
                w_next  = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_retired_cnt <= 32'd0;
            r_hold        <= 32'(RESET_PC_HOLD);
        end else begin
            r_state <= w_next;
            if (w_done) r_retired_cnt <= r_retired_cnt + 32'd1;
            if (r_state == S_FETCH && r_hold != 32'd0) r_hold <= r_hold - 32'd1;
        end
    end

    // Reset masks every control output the same cycle, so an in-flight
    // transaction is dropped before the state register is cleared.
    assign mem_req     = rst ? 1'b0 : w_mem_req;
    assign mem_we      = rst ? 1'b0 : w_mem_we;
    assign IorD        = rst ? 1'b0 : w_iord;
    assign IRWr        = rst ? 1'b0 : w_irwr;
    assign PCWr        = rst ? 1'b0 : w_pcwr;
    assign PCWrCond    = rst ? 1'b0 : w_pcwrcond;
    assign PCSrc       = rst ? 2'b00 : w_pcsrc;
    assign ALUSrcA     = rst ? 1'b0 : w_alusrca;
    assign ALUSrcB     = rst ? 2'b00 : w_alusrcb;
    assign ALUOp       = rst ? 2'b00 : w_aluop;
    assign RegWr       = rst ? 1'b0 : w_regwr;
    assign RegDst      = rst ? 1'b0 : w_regdst;
    assign MemToReg    = rst ? 1'b0 : w_memtoreg;
    assign Link        = rst ? 1'b0 : w_link;
    assign ExtOp       = rst ? 2'b00 : w_extop;
    assign instr_done  = rst ? 1'b0 : w_done;
    assign illegal     = rst ? 1'b0 : w_illegal;
    assign state       = r_state;
    assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard testbench for mc_ctrl
module tb_mc_ctrl;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst, zero, mem_ack;
    logic [5:0]  opcode, funct;
    logic        mem_req, mem_we, IorD, IRWr, PCWr, PCWrCond;
    logic [1:0]  PCSrc, ALUSrcB, ALUOp, ExtOp;
    logic        ALUSrcA, RegWr, RegDst, MemToReg, Link, instr_done, illegal;
    logic [3:0]  state;
    logic [31:0] retired_cnt;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
        .IRWr(IRWr), .PCWr(PCWr), .PCWrCond(PCWrCond), .PCSrc(PCSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWr(RegWr),
        .RegDst(RegDst), .MemToReg(MemToReg), .Link(Link), .ExtOp(ExtOp),
        .state(state), .instr_done(instr_done), .illegal(illegal),
        .retired_cnt(retired_cnt)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic        mem_req, mem_we, iord, irwr, pcwr, pcwrcond;
        logic [1:0]  pcsrc;
        logic        alusrca;
        logic [1:0]  alusrcb, aluop;
        logic        regwr, regdst, memtoreg, link;
        logic [1:0]  extop;
        logic        done, ill;
        logic [31:0] cnt;
    } ctl_t;

    ctl_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_cnt = 32'd0;

    // Monitor: compares every cycle for which stimulus queued an expectation.
    always @(negedge clk) begin
        ctl_t got, exp_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got = '{state, mem_req, mem_we, IorD, IRWr, PCWr, PCWrCond, PCSrc,
                    ALUSrcA, ALUSrcB, ALUOp, RegWr, RegDst, MemToReg, Link,
                    ExtOp, instr_done, illegal, retired_cnt};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL ctl check=%0d t=%0t got=%h exp=%h", checks, $time, got, exp_v);
            end
        end
    end

    function automatic ctl_t base(input logic [3:0] st);
        ctl_t e = '0;
        e.st  = st;
        e.cnt = model_cnt;
        return e;
    endfunction

    task automatic step(input ctl_t e);
        exp_q.push_back(e);
        if (e.done) model_cnt = model_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic t_fetch(input logic [5:0] op, input logic [5:0] fn, input logic ack);
        ctl_t e;
        opcode = op; funct = fn; mem_ack = ack;
        e = base(S_FETCH); e.mem_req = 1; e.alusrcb = 2'b01; e.irwr = ack; e.pcwr = ack;
        step(e);
    endtask

    task automatic t_decode(input logic ill);
        ctl_t e;
        mem_ack = 0;
        e = base(S_DECODE); e.alusrcb = 2'b11; e.done = ill; e.ill = ill;
        step(e);
    endtask

    task automatic t_wb_alu(input logic rd);
        ctl_t e;
        e = base(S_WB_ALU); e.regwr = 1; e.regdst = rd; e.done = 1;
        step(e);
    endtask

    task automatic i_rtype(input logic [5:0] fn);
        ctl_t e;
        t_fetch(6'h00, fn, 1); t_decode(0);
        e = base(S_EXEC_R); e.alusrca = 1; e.aluop = 2'b10; step(e);
        t_wb_alu(1);
    endtask

    task automatic i_itype(input logic [5:0] op, input logic [1:0] aop, input logic [1:0] ext);
        ctl_t e;
        t_fetch(op, 6'h3F, 1); t_decode(0);
        e = base(S_EXEC_I); e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = aop; e.extop = ext; step(e);
        t_wb_alu(0);
    endtask

    task automatic t_mem_addr();
        ctl_t e;
        e = base(S_MEM_ADDR); e.alusrca = 1; e.alusrcb = 2'b10; e.extop = 2'b01;
        step(e);
    endtask

    task automatic i_lw(input int waits);
        ctl_t e;
        t_fetch(6'h23, 6'h00, 1); t_decode(0); t_mem_addr();
        for (int i = 0; i <= waits; i++) begin
            mem_ack = (i == waits);
            e = base(S_MEM_RD); e.mem_req = 1; e.iord = 1; step(e);
        end
        mem_ack = 0;
        e = base(S_WB_MEM); e.regwr = 1; e.memtoreg = 1; e.done = 1; step(e);
    endtask

    task automatic t_mem_wr(input logic ack);
        ctl_t e;
        mem_ack = ack;
        e = base(S_MEM_WR); e.mem_req = 1; e.mem_we = 1; e.iord = 1; e.done = ack;
        step(e);
    endtask

    task automatic i_beq(input logic z);
        ctl_t e;
        zero = z;
        t_fetch(6'h04, 6'h00, 1); t_decode(0);
        e = base(S_BRANCH); e.alusrca = 1; e.aluop = 2'b01; e.pcwrcond = 1; e.pcsrc = 2'b01; e.done = 1;
        step(e);
    endtask

    task automatic i_jump(input logic [5:0] op, input logic lnk);
        ctl_t e;
        t_fetch(op, 6'h00, 1); t_decode(0);
        e = base(S_JUMP); e.pcwr = 1; e.pcsrc = 2'b10; e.link = lnk; e.regwr = lnk; e.done = 1;
        step(e);
    endtask

    initial begin
        ctl_t e;
        rst = 1; zero = 0; mem_ack = 0; opcode = 6'h00; funct = 6'h00;
        @(posedge clk); #1;
        e = base(S_FETCH); step(e);          // second reset cycle: everything 0
        rst = 0;

        i_rtype(6'h21);                      // addu
        i_itype(6'h0D, 2'b11, 2'b00);        // ori
        i_itype(6'h0F, 2'b11, 2'b10);        // lui
        i_itype(6'h09, 2'b00, 2'b01);        // addiu
        i_lw(3);                             // lw with 3 wait cycles
        i_lw(0);                             // lw zero wait
        t_fetch(6'h2B, 6'h00, 1); t_decode(0); t_mem_addr(); t_mem_wr(1);  // sw
        i_beq(1);
        i_beq(0);
        i_jump(6'h02, 0);                    // j
        i_jump(6'h03, 1);                    // jal
        t_fetch(6'h3F, 6'h00, 1); t_decode(1);   // illegal opcode
        t_fetch(6'h00, 6'h22, 1); t_decode(1);   // illegal R-type funct
        t_fetch(6'h00, 6'h2A, 0);                // fetch waits for ack
        i_rtype(6'h2A);

        // Reset in the second wait cycle of a store, with a stray ack.
        t_fetch(6'h2B, 6'h00, 1); t_decode(0); t_mem_addr(); t_mem_wr(0);
        rst = 1; mem_ack = 1;
        e = base(S_MEM_WR); step(e);
        rst = 0; model_cnt = 32'd0;
        t_fetch(6'h00, 6'h21, 0);            // late ack gone: no IRWr, count 0
        i_rtype(6'h21);

        // Counter wrap from a forced all-ones value.
        force dut.r_retired_cnt = 32'hFFFF_FFFF;
        model_cnt = 32'hFFFF_FFFF;
        t_fetch(6'h00, 6'h21, 0);
        release dut.r_retired_cnt;
        i_rtype(6'h24);
        t_fetch(6'h00, 6'h21, 0);            // wrapped to 0

        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
